// File: rtl/pipe_buffer_pkg.sv
// Core-wide shared definitions for the pipeline buffers between core stages.
package C;
   localparam int PIPE_DEPTH = 2;
endpackage

// File: rtl/pipe_buffer.sv
// Elastic pipeline buffer: circular storage with optional empty fall-through,
// synchronous flush for redirects and a saturating upstream stall counter.
module pipe_buffer
   import C::*;
#(
   parameter type T           = logic [63:0],
   parameter int  DEPTH       = PIPE_DEPTH,
   parameter bit  FALLTHROUGH = 1'b0,
   parameter int  CNT_W       = 32
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  T                             in_i,
   input  logic                         in_i_valid,
   output logic                         in_i_ready,
   output T                             out_o,
   output logic                         out_o_valid,
   input  logic                         out_o_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [CNT_W-1:0]             stall_cnt_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T                mem [DEPTH];
   logic [PW-1:0]   rd_reg, wr_reg;
   logic [CW-1:0]   count_reg;
   logic [CNT_W-1:0] stall_reg;

   logic empty, push, pop, bypass, store, pop_mem;

   // Wrap by compare so non-power-of-two depths work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty       = (count_reg == '0);
   assign in_i_ready  = (count_reg != CW'(DEPTH));
   assign count_o     = count_reg;
   assign stall_cnt_o = stall_reg;

   always_comb begin
      out_o       = mem[rd_reg];
      out_o_valid = !empty;
      if (FALLTHROUGH && empty) begin
         out_o       = in_i;
         out_o_valid = in_i_valid && !flush_i;
      end
   end

   assign push    = in_i_valid && in_i_ready && !flush_i;
   assign pop     = out_o_valid && out_o_ready;
   // An item that passes straight through an empty buffer is never stored.
   assign bypass  = FALLTHROUGH && empty && push && pop;
   assign store   = push && !bypass;
   assign pop_mem = pop && !empty;

   always_ff @(posedge clk) begin
      if (store && !rst) begin
         mem[wr_reg] <= in_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_reg    <= '0;
         wr_reg    <= '0;
         count_reg <= '0;
         stall_reg <= '0;
      end else begin
         if (in_i_valid && !in_i_ready && (stall_reg != {CNT_W{1'b1}})) begin
            stall_reg <= stall_reg + 1'b1;
         end
         if (flush_i) begin
            rd_reg    <= '0;
            wr_reg    <= '0;
            count_reg <= '0;
         end else begin
            if (store)   wr_reg <= next_ptr(wr_reg);
            if (pop_mem) rd_reg <= next_ptr(rd_reg);
            count_reg <= count_reg + CW'(store) - CW'(pop_mem);
         end
      end
   end
endmodule

// File: tb/tb_pipe_buffer.sv
// Bench: four buffer configurations on shared stimulus, each checked every cycle
// against a queue model, plus directed literal expectations.
module tb_pipe_buffer;
   localparam int NI = 4;

   function automatic int dep_of(input int i);
      case (i)
         0: return 2;
         1: return 3;
         2: return 3;
         default: return 1;
      endcase
   endfunction
   function automatic bit ft_of(input int i);
      return (i == 2);
   endfunction
   function automatic int cw_of(input int i);
      return (i == 1) ? 4 : 32;
   endfunction

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [63:0] in_data;

   logic [63:0] o_data  [NI];
   logic [NI-1:0] o_valid, o_ready;
   logic [7:0]  o_cnt   [NI];
   logic [31:0] o_stall [NI];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DI  = dep_of(gi);
      localparam int CWI = $clog2(DI + 1);
      localparam int SWI = cw_of(gi);
      logic [CWI-1:0] cnt;
      logic [SWI-1:0] st;
      pipe_buffer #(
         .T(logic [63:0]), .DEPTH(DI), .FALLTHROUGH(ft_of(gi)), .CNT_W(SWI)
      ) u_dut (
         .clk(clk), .rst(rst), .flush_i(flush),
         .in_i(in_data), .in_i_valid(in_valid), .in_i_ready(o_ready[gi]),
         .out_o(o_data[gi]), .out_o_valid(o_valid[gi]), .out_o_ready(out_ready),
         .count_o(cnt), .stall_cnt_o(st)
      );
      assign o_cnt[gi]   = 8'(cnt);
      assign o_stall[gi] = 32'(st);
   end

   // Behavioural model: contents as a FIFO queue, stall count as an integer.
   logic [63:0] mq [NI][$];
   longint      ms [NI];
   int tests = 0, fails = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit m_valid(input int i);
      return (mq[i].size() > 0) || (ft_of(i) && in_valid && !flush);
   endfunction
   function automatic bit m_ready(input int i);
      return mq[i].size() != dep_of(i);
   endfunction
   function automatic longint m_smax(input int i);
      return (longint'(1) << cw_of(i)) - 1;
   endfunction

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("d%0d valid", i), 64'(o_valid[i]), 64'(m_valid(i)));
         chk($sformatf("d%0d ready", i), 64'(o_ready[i]), 64'(m_ready(i)));
         chk($sformatf("d%0d count", i), 64'(o_cnt[i]), 64'(mq[i].size()));
         chk($sformatf("d%0d stall", i), 64'(o_stall[i]), 64'(ms[i]));
         if (m_valid(i))
            chk($sformatf("d%0d data", i), o_data[i],
                (mq[i].size() > 0) ? mq[i][0] : in_data);
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < NI; i++) begin
         bit v, r, pop, push;
         v = m_valid(i);
         r = m_ready(i);
         if (rst) begin
            mq[i].delete();
            ms[i] = 0;
         end else begin
            if (in_valid && !r && ms[i] < m_smax(i)) ms[i]++;
            if (flush) begin
               mq[i].delete();
            end else begin
               pop  = v && out_ready;
               push = in_valid && r;
               if (!(mq[i].size() == 0 && pop)) begin
                  if (pop)  void'(mq[i].pop_front());
                  if (push) mq[i].push_back(in_data);
               end
            end
         end
      end
   endtask

   task automatic half_a();
      @(negedge clk);
      compare_all();
   endtask
   task automatic half_b();
      @(posedge clk);
      model_update();
      #1;
   endtask
   task automatic tick();
      half_a();
      half_b();
   endtask
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] vals [3];
      logic [63:0] got_q [$];
      bit acc;
      for (int i = 0; i < NI; i++) ms[i] = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Post-reset outputs; fall-through instance mirrors a valid input.
      in_valid = 1'b1; in_data = 64'h99;
      half_a();
      chk("rst ready", 64'(o_ready[0]), 64'd1);
      chk("rst valid", 64'(o_valid[0]), 64'd0);
      chk("rst count", 64'(o_cnt[0]), 64'd0);
      chk("rst stall", 64'(o_stall[0]), 64'd0);
      chk("rst ft valid", 64'(o_valid[2]), 64'd1);
      half_b();

      // Back-to-back A,B,C into DEPTH=2: one-cycle latency.
      do_reset();
      vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = (k < 3);
         if (k < 3) in_data = vals[k];
         half_a();
         if (k >= 1) begin
            chk("abc data", o_data[0], vals[k-1]);
            chk("abc valid", 64'(o_valid[0]), 64'd1);
            $display("[TB] abc out %h", o_data[0]);
         end
         chk("abc cnt<=1", 64'(o_cnt[0] <= 8'd1), 64'd1);
         chk("abc stall", 64'(o_stall[0]), 64'd0);
         half_b();
      end

      // DEPTH=3 fill with blocked output; 4th item held, stall counts and saturates.
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 24; c++) begin
         in_valid = 1'b1;
         in_data  = (c < 3) ? 64'(c + 1) : 64'd4;
         half_a();
         if (c >= 3) begin
            chk("full count", 64'(o_cnt[1]), 64'd3);
            chk("full ready", 64'(o_ready[1]), 64'd0);
            chk("full stall", 64'(o_stall[1]), 64'((c - 3 > 15) ? 15 : c - 3));
         end
         half_b();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
         half_a();
         if (o_valid[1]) begin
            got_q.push_back(o_data[1]);
            $display("[TB] drain out %h", o_data[1]);
         end
         acc = in_valid && o_ready[1];
         half_b();
         if (acc) in_valid = 1'b0;
      end
      chk("drain n", 64'(got_q.size()), 64'd4);
      for (int k = 0; k < got_q.size() && k < 4; k++)
         chk("drain order", got_q[k], 64'(k + 1));

      // Reset mid-stream with contents and a saturated counter.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_data = 64'(100 + c);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      half_a();
      chk("mid rst ready", 64'(o_ready[1]), 64'd1);
      chk("mid rst valid", 64'(o_valid[1]), 64'd0);
      chk("mid rst count", 64'(o_cnt[1]), 64'd0);
      chk("mid rst stall", 64'(o_stall[1]), 64'd0);
      half_b();

      // Fall-through: empty buffer forwards in the same cycle, stores nothing.
      in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b1;
      half_a();
      chk("ft data", o_data[2], 64'h55);
      chk("ft valid", 64'(o_valid[2]), 64'd1);
      half_b();
      in_valid = 1'b0;
      half_a();
      chk("ft count", 64'(o_cnt[2]), 64'd0);
      chk("ft valid after", 64'(o_valid[2]), 64'd0);
      half_b();

      // Flush with a simultaneous push: everything dropped.
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 64'h11; tick();
      in_data = 64'h22; tick();
      flush = 1'b1; in_data = 64'h77;
      half_a();
      chk("pre flush count", 64'(o_cnt[0]), 64'd2);
      half_b();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         half_a();
         chk("flush count", 64'(o_cnt[0]), 64'd0);
         chk("flush valid", 64'(o_valid[0]), 64'd0);
         half_b();
      end

      // Randomized traffic with occasional flushes.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = (c < 300) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
         flush     = ($urandom % 40) == 0;
         in_data   = {$urandom, $urandom};
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
